// File: rtl/score_pkg.sv
// Shared types and helpers for the score sequencer: FSM state encoding and
// the counter-width function used to size the tick divider.
package score_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_PLAY  = 2'd2,
        ST_GAP   = 2'd3
    } state_e;

    // Bits needed to count 0..value-1 (at least one bit).
    function automatic int clog2(input int value);
        int w;
        w = 1;
        while ((1 << w) < value) begin
            w++;
        end
        return w;
    endfunction

endpackage

// File: rtl/tick_divider.sv
// Free-running divider that emits a one-cycle tick every TICK_CYCLES cycles;
// clear forces the count back to zero, hold freezes it without ticking.
module tick_divider
    import score_pkg::*;
#(
    parameter int TICK_CYCLES = 735000
) (
    input  logic clk,
    input  logic rst,
    input  logic clear_i,
    input  logic hold_i,
    output logic tick_o
);

    localparam int CNT_W = clog2(TICK_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_CYCLES - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             at_last;

    assign at_last = (cnt_q == CNT_LAST);
    assign tick_o  = at_last && !hold_i && !clear_i;

    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (!hold_i) begin
            cnt_d = at_last ? '0 : cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/score_sequencer.sv
// Steps through a score ROM note by note: fetch {dur,tone}, play the tone for
// its duration minus an articulation gap, then advance, wrap or finish.
module score_sequencer
    import score_pkg::*;
#(
    parameter int TICK_CYCLES = 735000,
    parameter int ADDR_W      = 10,
    parameter int ADDR_MAX    = 610,
    parameter int DUR_W       = 7,
    parameter int TONE_W      = 7,
    parameter int GAP_TICKS   = 1,
    parameter int ROM_LAT     = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              stop,
    input  logic              pause,
    input  logic              loop_en,
    input  logic [ADDR_W-1:0] start_addr,
    output logic [ADDR_W-1:0] addr,
    input  logic [DUR_W-1:0]  rom_dur,
    input  logic [TONE_W-1:0] rom_tone,
    output logic [TONE_W-1:0] tone,
    output logic              busy,
    output logic              note_strobe,
    output logic              done
);

    localparam logic [DUR_W:0]    GAP_W      = (DUR_W + 1)'(GAP_TICKS);
    localparam logic [1:0]        FETCH_LAST = 2'(ROM_LAT);
    localparam logic [ADDR_W-1:0] ADDR_LAST  = ADDR_W'(ADDR_MAX);

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [TONE_W-1:0]   tone_q, tone_d;
    logic                strobe_q, strobe_d;
    logic                done_q, done_d;
    logic [DUR_W-1:0]    dur_q, dur_d;
    logic [TONE_W-1:0]   note_tone_q, note_tone_d;
    logic [DUR_W:0]      elapsed_q, elapsed_d;
    logic [1:0]          fetch_q, fetch_d;

    logic                tick;
    logic                tick_clear;
    logic                note_end;
    logic                has_gap;
    logic [DUR_W:0]      total_ticks;
    logic [DUR_W:0]      play_ticks;
    logic [DUR_W:0]      elapsed_inc;

    // Counter is one bit wider than dur so dur = all-ones still yields dur+1.
    assign total_ticks = {1'b0, dur_q} + (DUR_W + 1)'(1);
    assign has_gap     = (GAP_TICKS > 0) && (total_ticks > GAP_W);
    assign play_ticks  = has_gap ? (total_ticks - GAP_W) : total_ticks;
    assign elapsed_inc = elapsed_q + (DUR_W + 1)'(1);
    assign tick_clear  = (state_q != ST_PLAY) && (state_q != ST_GAP);

    tick_divider #(
        .TICK_CYCLES(TICK_CYCLES)
    ) u_tick (
        .clk     (clk),
        .rst     (rst),
        .clear_i (tick_clear),
        .hold_i  (pause),
        .tick_o  (tick)
    );

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        tone_d      = '0;
        strobe_d    = 1'b0;
        done_d      = 1'b0;
        dur_d       = dur_q;
        note_tone_d = note_tone_q;
        elapsed_d   = elapsed_q;
        fetch_d     = fetch_q;
        note_end    = 1'b0;

        if (stop) begin
            state_d = ST_IDLE;
            addr_d  = start_addr;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        addr_d  = start_addr;
                        fetch_d = '0;
                        state_d = ST_FETCH;
                    end
                end
                ST_FETCH: begin
                    if (fetch_q == FETCH_LAST) begin
                        dur_d       = rom_dur;
                        note_tone_d = rom_tone;
                        elapsed_d   = '0;
                        strobe_d    = 1'b1;
                        tone_d      = pause ? '0 : rom_tone;
                        state_d     = ST_PLAY;
                    end else begin
                        fetch_d = fetch_q + 2'd1;
                    end
                end
                ST_PLAY: begin
                    tone_d = pause ? '0 : note_tone_q;
                    if (tick) begin
                        elapsed_d = elapsed_inc;
                        if (elapsed_inc == play_ticks) begin
                            tone_d = '0;
                            if (has_gap) begin
                                state_d = ST_GAP;
                            end else begin
                                note_end = 1'b1;
                            end
                        end
                    end
                end
                ST_GAP: begin
                    if (tick) begin
                        elapsed_d = elapsed_inc;
                        note_end  = (elapsed_inc == total_ticks);
                    end
                end
                default: state_d = ST_IDLE;
            endcase

            if (note_end) begin
                fetch_d = '0;
                if (addr_q < ADDR_LAST) begin
                    addr_d  = addr_q + ADDR_W'(1);
                    state_d = ST_FETCH;
                end else if (loop_en) begin
                    addr_d  = start_addr;
                    state_d = ST_FETCH;
                end else begin
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            addr_q      <= '0;
            tone_q      <= '0;
            strobe_q    <= 1'b0;
            done_q      <= 1'b0;
            dur_q       <= '0;
            note_tone_q <= '0;
            elapsed_q   <= '0;
            fetch_q     <= '0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            tone_q      <= tone_d;
            strobe_q    <= strobe_d;
            done_q      <= done_d;
            dur_q       <= dur_d;
            note_tone_q <= note_tone_d;
            elapsed_q   <= elapsed_d;
            fetch_q     <= fetch_d;
        end
    end

    assign addr        = addr_q;
    assign tone        = tone_q;
    assign busy        = (state_q != ST_IDLE);
    assign note_strobe = strobe_q;
    assign done        = done_q;

endmodule

// File: tb/tb_score_sequencer.sv
// Bench for score_sequencer: directed scenarios with literal timing checks plus
// a randomized run, all compared each cycle against a note-timeline model.
module tb_score_sequencer;

    localparam int TICK = 4;
    localparam int AMAX = 3;
    localparam int GAP  = 1;
    localparam int RLAT = 1;
    localparam int AW   = 10;
    localparam int DW   = 3;
    localparam int TW   = 7;
    localparam int F    = RLAT + 1;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          start = 1'b0;
    logic          stop = 1'b0;
    logic          pause = 1'b0;
    logic          loop_en = 1'b0;
    logic [AW-1:0] start_addr = '0;
    logic [AW-1:0] addr;
    logic [DW-1:0] rom_dur;
    logic [TW-1:0] rom_tone;
    logic [TW-1:0] tone;
    logic          busy, note_strobe, done;

    logic [DW-1:0] mem_dur  [0:15];
    logic [TW-1:0] mem_tone [0:15];

    int n_cmp = 0;
    int n_err = 0;
    bit chk_en = 1'b0;

    int tr_tone [0:63];
    int tr_addr [0:63];
    int tr_busy [0:63];
    int tr_strobe [0:63];
    int tr_done [0:63];

    always #5 clk = ~clk;

    score_sequencer #(
        .TICK_CYCLES(TICK), .ADDR_W(AW), .ADDR_MAX(AMAX), .DUR_W(DW),
        .TONE_W(TW), .GAP_TICKS(GAP), .ROM_LAT(RLAT)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .stop(stop), .pause(pause),
        .loop_en(loop_en), .start_addr(start_addr), .addr(addr),
        .rom_dur(rom_dur), .rom_tone(rom_tone), .tone(tone), .busy(busy),
        .note_strobe(note_strobe), .done(done)
    );

    // One-cycle-latency score ROM.
    always @(posedge clk) begin
        rom_dur  <= mem_dur[addr[3:0]];
        rom_tone <= mem_tone[addr[3:0]];
    end

    // Model: a note is a timeline of F fetch cycles then (dur+1)*TICK cycles;
    // m_t is the position in that timeline and stands still on paused cycles.
    bit m_active = 1'b0;
    int m_a = 0;
    int m_t = 0;
    int m_tone = 0;
    bit m_strobe = 1'b0;
    bit m_done = 1'b0;

    function automatic int tone_ticks(input int d);
        int tot;
        tot = d + 1;
        return (tot > GAP) ? tot - GAP : tot;
    endfunction

    always @(posedge clk) begin
        int d;
        m_strobe = 1'b0;
        m_done   = 1'b0;
        if (!rst) begin
            m_active = 1'b0;
            m_a = 0;
            m_t = 0;
        end else if (stop) begin
            m_active = 1'b0;
            m_a = int'(start_addr);
        end else if (!m_active) begin
            if (start) begin
                m_active = 1'b1;
                m_a = int'(start_addr);
                m_t = 0;
            end
        end else begin
            if (m_t < F || !pause) begin
                m_t++;
                m_strobe = (m_t == F);
            end
            d = int'(mem_dur[m_a % 16]);
            if (m_t == F + (d + 1) * TICK) begin
                if (m_a < AMAX) begin
                    m_a++;
                    m_t = 0;
                end else if (loop_en) begin
                    m_a = int'(start_addr);
                    m_t = 0;
                end else begin
                    m_active = 1'b0;
                    m_done = 1'b1;
                end
            end
        end
        d = int'(mem_dur[m_a % 16]);
        if (m_active && m_t >= F && m_t < F + tone_ticks(d) * TICK && !pause)
            m_tone = int'(mem_tone[m_a % 16]);
        else
            m_tone = 0;
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s @%0t: got %0d expected %0d", nm, $time, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            check("addr", 32'(addr), 32'(m_a));
            check("tone", 32'(tone), 32'(m_tone));
            check("busy", 32'(busy), 32'(m_active));
            check("note_strobe", 32'(note_strobe), 32'(m_strobe));
            check("done", 32'(done), 32'(m_done));
        end
    end

    task automatic kick(input logic [AW-1:0] sa);
        @(posedge clk);
        #1;
        start = 1'b1;
        stop = 1'b0;
        start_addr = sa;
    endtask

    // Record n cycles after a kick; index k is the cycle after the k-th edge.
    task automatic rec(input int n, input logic [AW-1:0] sa1, input int pf, input int pt,
                       input int st, input logic [AW-1:0] sa);
        for (int k = 1; k <= n; k++) begin
            @(posedge clk);
            #1;
            start = 1'b0;
            stop = 1'b0;
            if (k == 1) start_addr = sa1;
            pause = (k >= pf && k < pt);
            if (st > 0 && k == st) begin
                stop = 1'b1;
                start_addr = sa;
            end
            if (st > 0 && k == st + 1) begin
                stop = 1'b1;
                start = 1'b1;
            end
            @(negedge clk);
            tr_tone[k] = int'(tone);
            tr_addr[k] = int'(addr);
            tr_busy[k] = int'(busy);
            tr_strobe[k] = int'(note_strobe);
            tr_done[k] = int'(done);
        end
        pause = 1'b0;
    endtask

    initial begin
        int c40, c12;
        for (int i = 0; i < 16; i++) begin
            mem_dur[i] = 3'd1;
            mem_tone[i] = 7'd3;
        end
        mem_dur[0] = 3'd2; mem_tone[0] = 7'd40;
        mem_dur[1] = 3'd0; mem_tone[1] = 7'd12;
        mem_dur[2] = 3'd1; mem_tone[2] = 7'd5;
        mem_dur[3] = 3'd1; mem_tone[3] = 7'd7;

        rst = 1'b0;
        @(posedge clk);
        #1;
        chk_en = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("reset addr", 32'(addr), 32'd0);
        check("reset tone", 32'(tone), 32'd0);
        check("reset busy", 32'(busy), 32'd0);
        check("reset done", 32'(done), 32'd0);
        rst = 1'b1;

        // One-shot playback of addresses 0..3.
        loop_en = 1'b0;
        kick(10'd0);
        rec(45, 10'd0, 0, 0, 0, 10'd0);
        c40 = 0; c12 = 0;
        for (int k = 1; k <= 45; k++) begin
            if (tr_tone[k] == 40) c40++;
            if (tr_tone[k] == 12) c12++;
        end
        check("A strobe k2", 32'(tr_strobe[2]), 32'd0);
        check("A strobe k3", 32'(tr_strobe[3]), 32'd1);
        check("A tone k3", 32'(tr_tone[3]), 32'd40);
        check("A tone k10", 32'(tr_tone[10]), 32'd40);
        check("A gap k11", 32'(tr_tone[11]), 32'd0);
        check("A tone40 cycles", 32'(c40), 32'd8);
        check("A addr k14", 32'(tr_addr[14]), 32'd0);
        check("A addr k15", 32'(tr_addr[15]), 32'd1);
        check("A tone k17", 32'(tr_tone[17]), 32'd12);
        check("A tone12 cycles", 32'(c12), 32'd4);
        check("A nogap addr k21", 32'(tr_addr[21]), 32'd2);
        check("A busy k40", 32'(tr_busy[40]), 32'd1);
        check("A done k40", 32'(tr_done[40]), 32'd0);
        check("A done k41", 32'(tr_done[41]), 32'd1);
        check("A busy k41", 32'(tr_busy[41]), 32'd0);
        check("A addr k41", 32'(tr_addr[41]), 32'd3);
        check("A done k42", 32'(tr_done[42]), 32'd0);
        $display("scenario one-shot: %0d compares so far", n_cmp);

        // Looping from the last address wraps to start_addr=0.
        loop_en = 1'b1;
        kick(10'd3);
        rec(12, 10'd0, 0, 0, 0, 10'd0);
        check("B addr k10", 32'(tr_addr[10]), 32'd3);
        check("B addr k11", 32'(tr_addr[11]), 32'd0);
        check("B busy k11", 32'(tr_busy[11]), 32'd1);
        check("B done k11", 32'(tr_done[11]), 32'd0);
        @(posedge clk);
        #1;
        stop = 1'b1;
        loop_en = 1'b0;
        @(posedge clk);
        #1;
        stop = 1'b0;
        $display("scenario loop: %0d compares so far", n_cmp);

        // Pause for three cycles mid-note.
        kick(10'd0);
        rec(20, 10'd0, 4, 7, 0, 10'd0);
        c40 = 0;
        for (int k = 1; k <= 20; k++) if (tr_tone[k] == 40) c40++;
        check("C tone k4", 32'(tr_tone[4]), 32'd40);
        check("C paused k5", 32'(tr_tone[5]), 32'd0);
        check("C paused k7", 32'(tr_tone[7]), 32'd0);
        check("C resume k8", 32'(tr_tone[8]), 32'd40);
        check("C tone k13", 32'(tr_tone[13]), 32'd40);
        check("C gap k14", 32'(tr_tone[14]), 32'd0);
        check("C addr k17", 32'(tr_addr[17]), 32'd0);
        check("C addr k18", 32'(tr_addr[18]), 32'd1);
        check("C tone40 cycles", 32'(c40), 32'd8);

        // Two-cycle reset in the middle of the next note.
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        check("midreset addr", 32'(addr), 32'd0);
        check("midreset tone", 32'(tone), 32'd0);
        check("midreset busy", 32'(busy), 32'd0);
        check("midreset done", 32'(done), 32'd0);
        rst = 1'b1;
        $display("scenario pause/reset: %0d compares so far", n_cmp);

        // Stop mid-PLAY, then start and stop together while idle.
        kick(10'd2);
        rec(9, 10'd2, 0, 0, 5, 10'd1);
        check("D tone k4", 32'(tr_tone[4]), 32'd5);
        check("D busy k5", 32'(tr_busy[5]), 32'd1);
        check("D tone k6", 32'(tr_tone[6]), 32'd0);
        check("D busy k6", 32'(tr_busy[6]), 32'd0);
        check("D addr k6", 32'(tr_addr[6]), 32'd1);
        check("D busy k7", 32'(tr_busy[7]), 32'd0);
        check("D busy k8", 32'(tr_busy[8]), 32'd0);
        check("D addr k8", 32'(tr_addr[8]), 32'd1);
        $display("scenario stop: %0d compares so far", n_cmp);

        // Randomized score and control traffic.
        for (int i = 0; i < 16; i++) begin
            mem_dur[i] = DW'($urandom_range(0, 7));
            mem_tone[i] = TW'($urandom_range(0, 127));
        end
        mem_dur[1] = 3'd7;
        mem_tone[2] = 7'd0;
        for (int i = 0; i < 4000; i++) begin
            @(posedge clk);
            #1;
            rst = ($urandom_range(0, 199) != 0);
            stop = ($urandom_range(0, 59) == 0);
            start = ($urandom_range(0, 9) == 0);
            pause = ($urandom_range(0, 9) < 2);
            if (i % 50 == 0) loop_en = $urandom_range(0, 1) != 0;
            start_addr = AW'($urandom_range(0, 4));
        end
        @(posedge clk);
        #1;
        rst = 1'b1;
        stop = 1'b0;
        start = 1'b0;
        pause = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        #1;
        chk_en = 1'b0;
        $display("scenario random: %0d compares so far", n_cmp);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
